// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if #(
    parameter int ADDR_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         imem_req;
    logic [ADDR_WIDTH-1:0]        imem_addr;
    logic                         imem_ack;
    logic                         imem_rvalid;
    logic [INSTRUCTION_WIDTH-1:0] imem_rdata;
    logic                         imem_error;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rvalid,
        input  imem_rdata,
        input  imem_error
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rvalid,
        output imem_rdata,
        output imem_error
    );
endinterface

// File: rtl/fetch_stage.sv
// First pipeline stage: owns the fetch PC, issues one imem read at a
// time and buffers the returned word for decode.
module fetch_stage #(
    parameter int                    ADDR_WIDTH        = 32,
    parameter int                    INSTRUCTION_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR      = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         next_stall,
    output logic                         done_next,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_target,
    fetch_stage_if.master                imem,
    output logic [ADDR_WIDTH-1:0]        program_count_out,
    output logic                         program_count_valid_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_data_out,
    output logic                         instruction_data_valid_out
);
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0]                   state;
    logic [ADDR_WIDTH-1:0]        pc;
    logic                         discard;
    logic [ADDR_WIDTH-1:0]        buf_pc;
    logic [INSTRUCTION_WIDTH-1:0] buf_data;
    logic                         buf_ok;
    logic                         misaligned;
    logic                         req;

    assign misaligned = |pc[1:0];
    // rst gate keeps the request low while the async reset is held
    assign req = rst && (state == S_REQ) && !misaligned;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    assign done_next                  = (state == S_FULL);
    assign program_count_out          = buf_pc;
    assign program_count_valid_out    = done_next;
    assign instruction_data_out       = buf_data;
    assign instruction_data_valid_out = done_next && buf_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            pc       <= RESET_VECTOR;
            discard  <= 1'b0;
            buf_pc   <= '0;
            buf_data <= '0;
            buf_ok   <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_target;
            unique case (state)
                S_REQ: begin
                    if (req && imem.imem_ack) begin
                        state   <= S_WAIT;
                        discard <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        state   <= S_REQ;
                        discard <= 1'b0;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end else begin
            unique case (state)
                S_REQ: begin
                    if (misaligned) begin
                        buf_pc   <= pc;
                        buf_data <= '0;
                        buf_ok   <= 1'b0;
                        state    <= S_FULL;
                    end else if (imem.imem_ack) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= S_REQ;
                        end else begin
                            buf_pc   <= pc;
                            buf_data <= imem.imem_rdata;
                            buf_ok   <= !imem.imem_error;
                            pc       <= pc + ADDR_WIDTH'(4);
                            state    <= S_FULL;
                        end
                    end
                end
                default: begin
                    if (!next_stall) begin
                        state <= S_REQ;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a small variable-latency
// instruction memory model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        next_stall;
    logic        done_next;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] program_count_out;
    logic        program_count_valid_out;
    logic [31:0] instruction_data_out;
    logic        instruction_data_valid_out;

    int checks = 0;
    int errors = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk                        (clk),
        .rst                        (rst),
        .next_stall                 (next_stall),
        .done_next                  (done_next),
        .redirect_valid             (redirect_valid),
        .redirect_target            (redirect_target),
        .imem                       (bus.master),
        .program_count_out          (program_count_out),
        .program_count_valid_out    (program_count_valid_out),
        .instruction_data_out       (instruction_data_out),
        .instruction_data_valid_out (instruction_data_valid_out)
    );

    always #5 clk = ~clk;

    // memory: accepts at once, answers lat+1 cycles after the ack
    logic [3:0]  lat;
    logic [3:0]  cnt;
    logic        pend;
    logic [31:0] paddr;
    logic [31:0] err_addr;
    logic        req_seen;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h0000_0013 ^ (a << 8);
    endfunction

    assign bus.imem_ack    = bus.imem_req;
    assign bus.imem_rvalid = pend && (cnt == 4'd0);
    assign bus.imem_rdata  = word(paddr);
    assign bus.imem_error  = bus.imem_rvalid && (paddr == err_addr);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend  <= 1'b0;
            cnt   <= 4'd0;
            paddr <= 32'd0;
        end else begin
            if (pend) begin
                if (cnt == 4'd0) pend <= 1'b0;
                else cnt <= cnt - 4'd1;
            end
            if (bus.imem_req && bus.imem_ack) begin
                pend  <= 1'b1;
                cnt   <= lat;
                paddr <= bus.imem_addr;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.imem_req && bus.imem_addr == 32'h102) req_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_next) break;
        end
        check("done_wait", 32'(done_next), 32'd1);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_req) break;
        end
        check("req_wait", 32'(bus.imem_req), 32'd1);
    endtask

    task automatic pulse(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
        @(negedge clk);
        redirect_valid  = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        next_stall      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        lat             = 4'd0;
        err_addr        = 32'hFFFF_FFFF;
        req_seen        = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_done", 32'(done_next), 32'd0);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_dvalid", 32'(instruction_data_valid_out), 32'd0);
        rst = 1'b1;
        #1;
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr, 32'd0);

        wait_done();
        check("d0_pc", program_count_out, 32'd0);
        check("d0_pcv", 32'(program_count_valid_out), 32'd1);
        check("d0_data", instruction_data_out, 32'h0000_0013);
        check("d0_valid", 32'(instruction_data_valid_out), 32'd1);
        wait_req();
        check("addr4", bus.imem_addr, 32'd4);

        wait_done();
        check("d4_pc", program_count_out, 32'd4);
        wait_req();
        check("addr8", bus.imem_addr, 32'd8);
        next_stall = 1'b1;
        wait_done();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("stall_done", 32'(done_next), 32'd1);
            check("stall_pc", program_count_out, 32'd8);
            check("stall_data", instruction_data_out, word(32'd8));
            check("stall_req", 32'(bus.imem_req), 32'd0);
        end
        @(negedge clk);
        next_stall = 1'b0;
        check("stall6_done", 32'(done_next), 32'd1);
        wait_req();
        check("addr12", bus.imem_addr, 32'd12);

        lat = 4'd3;
        @(negedge clk);
        check("wait12_req", 32'(bus.imem_req), 32'd0);
        pulse(32'h100);
        lat = 4'd0;
        wait_req();
        check("redir_addr", bus.imem_addr, 32'h100);
        wait_done();
        check("redir_pc", program_count_out, 32'h100);
        check("redir_data", instruction_data_out, word(32'h100));

        wait_req();
        pulse(32'h20);
        wait_req();
        check("addr20", bus.imem_addr, 32'h20);
        pulse(32'h40);
        wait_req();
        check("addr40", bus.imem_addr, 32'h40);
        wait_done();
        check("d40_pc", program_count_out, 32'h40);

        err_addr = 32'h10;
        wait_req();
        pulse(32'h10);
        wait_done();
        check("err_pc", program_count_out, 32'h10);
        check("err_pcv", 32'(program_count_valid_out), 32'd1);
        check("err_valid", 32'(instruction_data_valid_out), 32'd0);
        wait_req();
        check("err_next", bus.imem_addr, 32'h14);

        wait_req();
        pulse(32'hFFFF_FFFC);
        wait_done();
        check("wrap_pc", program_count_out, 32'hFFFF_FFFC);
        check("wrap_valid", 32'(instruction_data_valid_out), 32'd1);
        wait_req();
        check("wrap_next", bus.imem_addr, 32'd0);

        req_seen = 1'b0;
        pulse(32'h102);
        wait_done();
        check("mis_pc", program_count_out, 32'h102);
        check("mis_valid", 32'(instruction_data_valid_out), 32'd0);
        check("mis_noreq", 32'(req_seen), 32'd0);
        pulse(32'h200);
        check("mis_leave", 32'(bus.imem_req), 32'd1);
        check("addr200", bus.imem_addr, 32'h200);

        lat = 4'd3;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_done", 32'(done_next), 32'd0);
        check("mid_rst_req", 32'(bus.imem_req), 32'd0);
        lat = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_req", 32'(bus.imem_req), 32'd1);
        check("post_rst_addr", bus.imem_addr, 32'd0);
        wait_done();
        check("post_rst_pc", program_count_out, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
